// File: rtl/i2c_slave_pkg.sv
// Shared types and widths for the I2C write-only FIFO target.
package i2c_slave_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int I2C_WORD_W = 15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_slave_state_e;
endpackage

// File: rtl/i2c_fifo_slave_if.sv
// Bus pins plus local FIFO drain port of the I2C FIFO target.
interface i2c_fifo_slave_if;
  import i2c_slave_pkg::*;

  logic [I2C_ADDR_W-1:0] own_addr_in;
  logic                  i2c_sda_in;
  logic                  i2c_scl_in;
  logic                  sda_pull_out;
  logic                  fifo_rd_en;
  logic [I2C_WORD_W-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  overflow_out;
  logic                  ovf_clr_in;
  logic                  busy_out;

  modport slave (
    input  own_addr_in, i2c_sda_in, i2c_scl_in, fifo_rd_en, ovf_clr_in,
    output sda_pull_out, fifo_dout, fifo_empty, fifo_full, overflow_out, busy_out
  );

  modport master (
    output own_addr_in, i2c_sda_in, i2c_scl_in, fifo_rd_en, ovf_clr_in,
    input  sda_pull_out, fifo_dout, fifo_empty, fifo_full, overflow_out, busy_out
  );
endinterface

// File: rtl/i2c_bus_sampler.sv
// Synchronizes SDA/SCL and decodes SCL edges plus START/STOP conditions.
module i2c_bus_sampler (
  input  logic clk_in,
  input  logic reset_in,
  input  logic sda,
  input  logic scl,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] sda_sync, scl_sync;
  logic       sda_q, scl_q;
  logic [2:0] vld_pipe;
  logic       scl_s, live;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sda_sync <= 2'b11;
      scl_sync <= 2'b11;
      sda_q    <= 1'b1;
      scl_q    <= 1'b1;
      vld_pipe <= '0;
    end else begin
      sda_sync <= {sda_sync[0], sda};
      scl_sync <= {scl_sync[0], scl};
      sda_q    <= sda_sync[1];
      scl_q    <= scl_sync[1];
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  // Events stay masked until real pin levels have reached the history flop,
  // so releasing reset with the bus mid-byte cannot fake an edge or START.
  assign live     = vld_pipe[2];
  assign sda_s    = sda_sync[1];
  assign scl_s    = scl_sync[1];
  assign scl_rise = live &  scl_s & ~scl_q;
  assign scl_fall = live & ~scl_s &  scl_q;
  assign start    = live &  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop     = live &  scl_s &  scl_q & ~sda_q &  sda_s;
endmodule

// File: rtl/i2c_fifo_slave.sv
// I2C write-only target: address match, byte receive, ACK/NACK, receive FIFO.
module i2c_fifo_slave
  import i2c_slave_pkg::*;
#(
  parameter int                    DEPTH     = 16,
  parameter logic [I2C_ADDR_W-1:0] ADDR_MASK = 7'h7F
) (
  input logic              clk_in,
  input logic              reset_in,
  i2c_fifo_slave_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sampler u_sampler (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .sda      (bus.i2c_sda_in),
    .scl      (bus.i2c_scl_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_slave_state_e      state;
  logic [2:0]            bit_cnt;
  logic [I2C_DATA_W-1:0] shreg;
  logic                  byte_done;
  logic [I2C_ADDR_W-1:0] addr_lat;
  logic                  sda_pull, busy, ovf;

  logic [I2C_WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty, data_end, do_push, do_pop, ovf_set, addr_match;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign addr_match = (((shreg[7:1] ^ bus.own_addr_in) & ADDR_MASK) == '0) && !shreg[0];

  // Byte boundary of a data byte: push or NACK decided on the registered count.
  assign data_end = (state == DATA) && byte_done && scl_fall && !start && !stop;
  assign do_push  = data_end && !full;
  assign ovf_set  = data_end &&  full;
  assign do_pop   = bus.fifo_rd_en && !empty;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      addr_lat  <= '0;
      sda_pull  <= 1'b0;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= ADDR;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      sda_pull  <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      sda_pull  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise && !byte_done) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done <= 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            if (state == ADDR) begin
              if (addr_match) begin
                addr_lat <= shreg[7:1];
                busy     <= 1'b1;
                sda_pull <= 1'b1;
                state    <= ADDR_ACK;
              end else begin
                state    <= IGNORE;
              end
            end else begin
              sda_pull <= !full;
              state    <= DATA_ACK;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_pull <= 1'b0;
            state    <= DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= {addr_lat, shreg};
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)             ovf <= 1'b1;
      else if (bus.ovf_clr_in) ovf <= 1'b0;
    end
  end

  assign bus.sda_pull_out = sda_pull;
  assign bus.busy_out     = busy;
  assign bus.overflow_out = ovf;
  assign bus.fifo_empty   = empty;
  assign bus.fifo_full    = full;
  assign bus.fifo_dout    = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_i2c_fifo_slave.sv
// Scoreboard bench: bit-banged I2C master, queue reference model, ACK and pop monitors.
module tb_i2c_fifo_slave;
  localparam int DEPTH = 16;
  localparam int Q     = 4;
  localparam logic [6:0] OWN = 7'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sda_drv = 1'b1;
  always #5 clk = ~clk;

  i2c_fifo_slave_if bus();
  assign bus.i2c_sda_in = sda_drv & ~bus.sda_pull_out;

  i2c_fifo_slave #(.DEPTH(DEPTH), .ADDR_MASK(7'h7F)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [14:0] mdl[$];
  bit          exp_ack[$];
  logic [7:0]  tx[$];
  bit          ovf_exp = 1'b0;
  bit          in_ack  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; qwait();
    bus.i2c_scl_in = 1'b1; qwait();
    sda_drv = 1'b0; qwait();
    bus.i2c_scl_in = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; qwait();
    bus.i2c_scl_in = 1'b1; qwait();
    sda_drv = 1'b1; qwait();
  endtask

  task automatic send_bit(input bit b);
    sda_drv = b; qwait();
    bus.i2c_scl_in = 1'b1; qwait(); qwait();
    bus.i2c_scl_in = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1;
    exp_ack.push_back(ack);
    in_ack = 1'b1;
    qwait();
    bus.i2c_scl_in = 1'b1; qwait(); qwait();
    bus.i2c_scl_in = 1'b0;
    in_ack = 1'b0;
    qwait();
  endtask

  // Reference: a write addressed to OWN with rw=0 is taken; each byte is
  // accepted while the target FIFO has room, otherwise NACKed and flagged.
  task automatic xfer(input logic [6:0] a, input bit rw);
    bit hit;
    hit = (a == bus.own_addr_in) && !rw;
    bus_start();
    send_byte({a, rw}, hit);
    chk("busy_after_addr", bus.busy_out, hit);
    foreach (tx[i]) begin
      bit ok;
      ok = hit && (mdl.size() < DEPTH);
      if (ok) mdl.push_back({a, tx[i]});
      if (hit && !ok) ovf_exp = 1'b1;
      send_byte(tx[i], ok);
    end
    bus_stop();
    chk("busy_after_stop", bus.busy_out, 0);
    chk("overflow", bus.overflow_out, ovf_exp);
  endtask

  task automatic check_head();
    chk("empty", bus.fifo_empty, mdl.size() == 0);
    chk("full", bus.fifo_full, mdl.size() == DEPTH);
    if (mdl.size() != 0) chk("head", bus.fifo_dout, mdl[0]);
  endtask

  task automatic drain();
    bus.fifo_rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 4 && !bus.fifo_empty; i++) begin
      @(posedge clk); #1;
    end
    bus.fifo_rd_en = 1'b0;
    chk("drain_empty", bus.fifo_empty, 1);
  endtask

  always @(posedge bus.i2c_scl_in) begin
    if (in_ack) begin
      bit e;
      repeat (3) @(negedge clk);
      if (exp_ack.size() == 0) begin
        vectors++; errors++;
        $display("FAIL ack_slot: got unexpected slot, required none queued");
      end else begin
        e = exp_ack.pop_front();
        chk("ack", bus.sda_pull_out, e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.fifo_rd_en && !bus.fifo_empty) begin
      if (mdl.size() == 0) begin
        vectors++; errors++;
        $display("FAIL pop: got word %0h, required no entry", bus.fifo_dout);
      end else begin
        logic [14:0] w;
        w = mdl.pop_front();
        chk("pop_word", bus.fifo_dout, w);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_sda_pull", bus.sda_pull_out, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_full", bus.fifo_full, 0);
    chk("rst_dout", bus.fifo_dout, 0);
    chk("rst_ovf", bus.overflow_out, 0);
    chk("rst_busy", bus.busy_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.own_addr_in = OWN;
    bus.i2c_scl_in  = 1'b1;
    bus.fifo_rd_en  = 1'b0;
    bus.ovf_clr_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    qwait();

    // basic write
    tx = '{8'h42};
    xfer(7'h2A, 1'b0);
    chk("basic_head", bus.fifo_dout, 15'h2A42);
    check_head();
    drain();

    // mismatched address
    tx = '{8'h99};
    xfer(7'h15, 1'b0);
    check_head();

    // read request to own address
    tx = '{8'h11, 8'h22};
    xfer(OWN, 1'b1);
    check_head();

    // fill past DEPTH without popping
    tx.delete();
    for (int i = 0; i < DEPTH + 1; i++) tx.push_back(8'($urandom));
    xfer(OWN, 1'b0);
    check_head();
    bus.ovf_clr_in = 1'b1; @(posedge clk); #1;
    bus.ovf_clr_in = 1'b0; ovf_exp = 1'b0;
    chk("ovf_cleared", bus.overflow_out, 0);
    drain();

    // repeated START mid-byte, drained live with rd_en held high
    bus.fifo_rd_en = 1'b1;
    bus_start();
    send_byte({OWN, 1'b0}, 1'b1);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    tx = '{8'h5A};
    xfer(OWN, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.fifo_rd_en = 1'b0;
    check_head();

    // reset in the middle of a byte
    tx = '{8'h77};
    xfer(OWN, 1'b0);
    bus_start();
    send_byte({OWN, 1'b0}, 1'b1);
    send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    mdl.delete();
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("post_rst_empty", bus.fifo_empty, 1);
    bus_stop();
    tx = '{8'hC3};
    xfer(OWN, 1'b0);
    chk("post_rst_head", bus.fifo_dout, 15'h2AC3);
    drain();

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      logic [6:0] a;
      bit rw, live_rd;
      int n;
      a = ($urandom_range(0, 2) != 0) ? OWN : 7'($urandom);
      if ($urandom_range(0, 2) == 0 && a != OWN) a = a;
      else if (a != OWN) a = a ^ 7'h01;
      if (a == OWN && $urandom_range(0, 3) != 0) a = OWN;
      rw = ($urandom_range(0, 4) == 0);
      n = $urandom_range(1, 4);
      live_rd = ($urandom_range(0, 2) == 0);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
      bus.fifo_rd_en = live_rd;
      xfer(a, rw);
      repeat (4) @(posedge clk);
      #1;
      bus.fifo_rd_en = 1'b0;
      check_head();
      if (mdl.size() > 8) drain();
    end
    drain();
    chk("ack_queue_drained", exp_ack.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/i2c_fifo_slave.md
# i2c_fifo_slave

I2C write-only target with a receive FIFO; the counterpart to the team's FIFO-fed I2C master. It watches the bus pins, detects START/STOP, matches the 7-bit address, shifts in write data bytes, drives ACK/NACK, and pushes each received `{addr, data}` word into an internal FIFO. Local logic drains that FIFO. It sits on the target side of the bus, either in the loopback bench or in a peripheral.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `ADDR_MASK`, 7'h7F: address bits compared against `own_addr_in`; 0 bits are don't-care.
- `clk_in` input 1: single system clock; must be ≥ 8× the SCL frequency.
- `reset_in` input 1: asynchronous, active-low reset.
- `own_addr_in` input 7: target address; must be held stable outside transactions.
- `i2c_sda_in` input 1: SDA pin level.
- `i2c_scl_in` input 1: SCL pin level.
- `sda_pull_out` output 1: 1 pulls SDA low (ACK); open-drain enable; SCL is never stretched.
- `fifo_rd_en` input 1: pop the head entry; ignored when empty.
- `fifo_dout` output 15: head entry `{addr[6:0], data[7:0]}`; first-word fall-through.
- `fifo_empty` output 1: FIFO holds 0 entries.
- `fifo_full` output 1: FIFO holds `DEPTH` entries.
- `overflow_out` output 1: sticky; a byte was NACKed because the FIFO was full.
- `ovf_clr_in` input 1: clears `overflow_out`.
- `busy_out` output 1: high from an addressed START until STOP.

## Operation
- **Bus sampling:** two-flop synchronizer on SDA and SCL, then one history register. The sampler produces these events:
  - SCL rise and SCL fall.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
- **State machine:** IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - A 3-bit bit counter and an 8-bit shift register sample SDA on SCL rise, MSB first.
- START in any state → ADDR. The counter and shift register clear, and any partial byte is discarded (repeated start).
- STOP in any state → IDLE. `sda_pull_out`=0 and `busy_out`=0.
- ADDR: on the 8th bit, the target checks the received byte `{a[6:0], rw}`.
  - It matches when `(a ^ own_addr_in) & ADDR_MASK == 0` and `rw==0`.
  - On the next SCL fall: on a match, latch `a`, set `busy_out`=1, assert `sda_pull_out`, and go to ADDR_ACK. Otherwise go to IGNORE with SDA released.
- ADDR_ACK: on the next SCL fall, release SDA and go to DATA.
- DATA: after 8 bits, on the next SCL fall, go to DATA_ACK and act on the FIFO state:
  - If not full: push `{latched a, byte}` and assert `sda_pull_out` in the same cycle.
  - If full: no push, SDA released (NACK), and `overflow_out`←1.
- DATA_ACK: on the next SCL fall, release SDA and go to DATA. Multi-byte writes continue until STOP.
- IGNORE: no SDA drive; leave only on START or STOP.
- **FIFO:** `DEPTH` × 15-bit array with wrapping read/write pointers and a `log2(DEPTH)+1`-bit count.
  - Full and empty are judged on the registered count at the start of the cycle.
  - A push when full is rejected even if a pop occurs in the same cycle.
  - A pop when empty is ignored, including when a push occurs in the same cycle.
  - A simultaneous push and pop in any other state leaves the count unchanged.
- **Overflow flag:** `ovf_clr_in` and a new overflow in the same cycle → `overflow_out` stays 1.

## Timing
- **Reset values:** `sda_pull_out`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_dout`=0, `overflow_out`=0, `busy_out`=0. State is IDLE, pointers and count are 0, and the array contents are don't-care.
- **Event latency:** a pin change is acted on 3 `clk_in` cycles after it occurs (2 sync + 1 edge).
- **Push:** `sda_pull_out` asserts and the push is registered in the same cycle. `fifo_empty` falls and `fifo_dout` is valid on the next cycle.
- **Pop:** `fifo_rd_en` sampled high → `fifo_dout` shows the next entry, and the flags update, on the following cycle.
- **Reset mid-operation:** reset asserted mid-byte forces all reset values immediately. Bus activity before the next START is ignored (the state is IDLE).

## Structure
- Package `i2c_slave_pkg`:
  - the state enum `i2c_slave_state_e`;
  - constants `I2C_ADDR_W`=7, `I2C_DATA_W`=8, `I2C_WORD_W`=15.
- Sub-module `i2c_bus_sampler`: synchronizers, SCL rise/fall detection, START/STOP detection.
- The FSM and FIFO stay in `i2c_fifo_slave`.

## Test plan
- Write data 8'h42 to address 7'h2A with `own_addr_in`=7'h2A → `sda_pull_out` during both ACK slots; `fifo_dout`=15'h2A42 and `fifo_empty`=0.
- Address 7'h15 with `own_addr_in`=7'h2A, then data 8'h99 → no ACK, no push, IGNORE until STOP; `fifo_empty` stays 1.
- Matching address with rw=1 → NACK and no `busy_out`; subsequent bytes ignored.
- 17 bytes in one transaction with `DEPTH`=16 and no pops → first 16 ACKed, 17th NACKed; `fifo_full`=1, `overflow_out`=1, head still holds the first byte. Pulse `ovf_clr_in` → `overflow_out`=0.
- Repeated START after 5 bits of a data byte, then a full write of 8'h5A → only 8'h5A is pushed. Also drain with `fifo_rd_en` held high and a simultaneous push at count=0 → the pop is ignored.
- Assert `reset_in`=0 mid-byte → all outputs at reset values. After release, a 7'h2A/8'hC3 write → `fifo_dout`=15'h2AC3.
